// File: rtl/mem_ctrl_if.sv
// Request, response and byte-wide RAM-port bundle for mem_ctrl.
// The controller takes the slave view; the requesters and RAM take the master view.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_data;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_len;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  logic              flush;

  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_len, ls_addr, ls_wdata, flush, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_len, ls_addr, ls_wdata, flush, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide synchronous-read RAM port between instruction fetch and load/store,
// splitting each 1/2/4-byte access into byte beats and assembling little-endian read data.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;
  typedef enum logic {OwnIf, OwnLs} owner_e;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_owner_q;
  logic [1:0]        cnt_q;
  logic [2:0]        len_q;
  logic              prime_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;

  logic              if_done_q;
  logic [DATA_W-1:0] if_data_q;
  logic              ls_done_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;

  logic              if_eff;
  logic              grant_ls;
  logic              grant_if;
  logic [2:0]        ls_n;
  logic              last_beat;
  logic              more_addr;
  logic [DATA_W-1:0] asm_d;

  always_comb begin
    if_eff   = bus.if_req & ~bus.flush;
    // On a tie the requester that did not own the previous transaction wins.
    grant_ls = bus.ls_req & (~if_eff | (last_owner_q == OwnIf));
    grant_if = if_eff & ~grant_ls;

    unique case (bus.ls_len)
      2'b00:   ls_n = 3'd1;
      2'b01:   ls_n = 3'd2;
      default: ls_n = 3'd4;
    endcase

    last_beat = ({1'b0, cnt_q} == (len_q - 3'd1));
    more_addr = (({1'b0, cnt_q} + 3'd2) < len_q);

    asm_d = data_q;
    asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      last_owner_q <= OwnIf;
      cnt_q        <= '0;
      len_q        <= '0;
      prime_q      <= 1'b0;
      wdata_q      <= '0;
      data_q       <= '0;
      if_done_q    <= 1'b0;
      if_data_q    <= '0;
      ls_done_q    <= 1'b0;
      ls_rdata_q   <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_ls || grant_if) begin
            owner_q      <= grant_ls ? OwnLs : OwnIf;
            last_owner_q <= grant_ls ? OwnLs : OwnIf;
            mem_a_q      <= grant_ls ? bus.ls_addr : bus.if_addr;
            len_q        <= grant_ls ? ls_n : 3'd4;
            cnt_q        <= '0;
            prime_q      <= 1'b1;
            data_q       <= '0;
            if (grant_ls && bus.ls_we) begin
              state_q    <= StWr;
              mem_dout_q <= bus.ls_wdata[7:0];
              mem_wr_q   <= 1'b1;
              wdata_q    <= bus.ls_wdata >> 8;
            end else begin
              state_q    <= StRd;
            end
          end
        end

        StRd: begin
          if (owner_q == OwnIf && bus.flush) begin
            state_q <= StIdle;
          end else if (prime_q) begin
            // First RD cycle only issues address; its byte arrives next cycle.
            prime_q <= 1'b0;
            if (len_q != 3'd1) begin
              mem_a_q <= mem_a_q + ADDR_W'(1);
            end
          end else begin
            data_q <= asm_d;
            if (last_beat) begin
              state_q <= StDone;
              if (owner_q == OwnIf) begin
                if_done_q <= 1'b1;
                if_data_q <= asm_d;
              end else begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= asm_d;
              end
            end else begin
              cnt_q <= cnt_q + 2'd1;
              if (more_addr) begin
                mem_a_q <= mem_a_q + ADDR_W'(1);
              end
            end
          end
        end

        StWr: begin
          if (last_beat) begin
            mem_wr_q  <= 1'b0;
            ls_done_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            mem_a_q    <= mem_a_q + ADDR_W'(1);
            mem_dout_q <= wdata_q[7:0];
            wdata_q    <= wdata_q >> 8;
            cnt_q      <= cnt_q + 2'd1;
          end
        end

        StDone: begin
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized single transactions,
// checked against a byte-addressed memory model and latency rules.
module tb_mem_ctrl;

  logic clk;
  logic rst;

  mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total;
  int bad;

  // RAM seen by the DUT; low 13 address bits index it (test addresses never alias).
  logic [7:0]  ram [0:8191];
  logic        pk_en;
  logic [31:0] pk_a;
  logic [7:0]  pk_d;

  // Reference memory contents, keyed by full address.
  logic [7:0]  ref_mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pk_en) ram[pk_a[12:0]] <= pk_d;
    else if (bus.mem_wr === 1'b1) ram[bus.mem_a[12:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[12:0]];
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    pk_a  = a;
    pk_d  = d;
    pk_en = 1'b1;
    @(posedge clk);
    #1;
    pk_en = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_len   = 2'b00;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One transaction from an idle controller. flush_cyc is the cycle (0 = request cycle)
  // in which flush is pulsed, or -1 for none.
  task automatic run_txn(input bit is_ls, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int flush_cyc);
    int n, g, lat, done_at, n_done, n_other, k;
    bit store, kill, dn, dother;
    logic [31:0] exp_d, got_d;
    store = is_ls && we;
    n = !is_ls ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
    g = (!is_ls && flush_cyc == 0) ? 1 : 0;
    kill = !is_ls && flush_cyc >= g + 1 && flush_cyc <= g + n + 1;
    lat = store ? n + 1 : n + 2;
    exp_d = '0;
    for (int j = 0; j < n; j++) exp_d[8*j +: 8] = ref_rd(addr + 32'(j));
    done_at = -1;
    n_done = 0;
    n_other = 0;
    got_d = '0;
    if (is_ls) begin
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_len = len;
      bus.ls_addr = addr; bus.ls_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int i = 0; i <= g + lat + 2; i++) begin
      bus.flush = (i == flush_cyc);
      @(negedge clk);
      if (store) begin
        if (i >= g + 1 && i <= g + n) begin
          k = i - g - 1;
          chk("st_wr", bus.mem_wr, 32'd1);
          chk("st_a", bus.mem_a, addr + 32'(k));
          chk("st_d", bus.mem_dout, wdata[8*k +: 8]);
        end else begin
          chk("st_nowr", bus.mem_wr, 32'd0);
        end
      end else begin
        chk("rd_nowr", bus.mem_wr, 32'd0);
        if (i >= g + 1 && i <= g + n && !(kill && i > flush_cyc))
          chk("rd_a", bus.mem_a, addr + 32'(i - g - 1));
      end
      dn     = is_ls ? bus.ls_done : bus.if_done;
      dother = is_ls ? bus.if_done : bus.ls_done;
      if (dn) begin
        n_done++;
        if (done_at < 0) begin
          done_at = i;
          got_d = is_ls ? bus.ls_rdata : bus.if_data;
        end
      end
      if (dother) n_other++;
      @(posedge clk);
      #1;
      if (i == done_at || (kill && i == flush_cyc)) begin
        if (is_ls) bus.ls_req = 1'b0;
        else bus.if_req = 1'b0;
      end
    end
    bus.flush = 1'b0;
    chk("done_cnt", n_done, kill ? 32'd0 : 32'd1);
    chk("other_done", n_other, 32'd0);
    if (!kill) begin
      chk("latency", done_at, g + lat);
      if (!store) chk("rdata", got_d, exp_d);
    end
    if (store)
      for (int j = 0; j < n; j++) ref_mem[addr + 32'(j)] = wdata[8*j +: 8];
  endtask

  initial begin
    int exp_own [6];
    int exp_cyc [6];
    int rem_if, rem_ls, last, nd, n_if, n_ls, who, bad_a;
    logic [31:0] exp_if, exp_ls, got, a, wd;
    bit is_ls, we;
    logic [1:0] len;
    int fc;

    total = 0;
    bad = 0;
    pk_en = 1'b0;
    pk_a = '0;
    pk_d = '0;
    clear_inputs();
    rst = 1'b1;

    // Preload RAM and reference memory together while held in reset.
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    for (int j = 0; j < 4; j++) poke(32'h200 + 32'(j), 8'h5A);
    for (int j = 0; j < 4; j++) poke(32'h300 + 32'(j), 8'(8'hA0 + j));
    for (int j = 0; j < 4; j++) poke(32'h400 + 32'(j), 8'(8'hC0 + j));
    for (int j = 0; j < 4; j++) poke(32'h500 + 32'(j), 8'(8'h50 + j));
    for (int j = 0; j < 4; j++) poke(32'h600 + 32'(j), 8'(8'h60 + j));
    for (int j = 0; j < 4; j++) poke(32'h700 + 32'(j), 8'h00);
    for (int j = 0; j < 8; j++) poke(32'(j), 8'($urandom_range(255, 0)));
    for (int j = 0; j < 8; j++) poke(32'hFFFF_FFF8 + 32'(j), 8'($urandom_range(255, 0)));
    poke(32'hFFFF_FFFE, 8'h12);
    poke(32'hFFFF_FFFF, 8'h80);
    poke(32'h0, 8'h34);
    poke(32'h1, 8'h56);
    for (int j = 0; j < 256; j++) poke(32'h1000 + 32'(j), 8'($urandom_range(255, 0)));

    reset_dut();
    @(negedge clk);
    chk("rst_if_done", bus.if_done, 32'd0);
    chk("rst_ls_done", bus.ls_done, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_dout", bus.mem_dout, 32'd0);
    chk("rst_mem_wr", bus.mem_wr, 32'd0);
    @(posedge clk);
    #1;

    // Fetch word, half store, byte load at top of memory, wrapping word load.
    run_txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, -1);
    chk("fetch_word", bus.if_data, 32'h44332211);
    run_txn(1'b1, 1'b1, 2'b01, 32'h200, 32'hAABBCCDD, -1);
    chk("st_ram0", ram[13'h200], 32'hDD);
    chk("st_ram1", ram[13'h201], 32'hCC);
    chk("st_keep", ram[13'h202], 32'h5A);
    run_txn(1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, -1);
    chk("ld_byte", bus.ls_rdata, 32'h00000080);
    run_txn(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, -1);
    chk("ld_wrap", bus.ls_rdata, 32'h56348012);

    // Both requesters held for three transactions each after a fresh reset.
    reset_dut();
    rem_if = 3; rem_ls = 3; last = 0;
    for (int j = 0; j < 6; j++) begin
      if (rem_if > 0 && rem_ls > 0) who = (last == 0) ? 1 : 0;
      else who = (rem_ls > 0) ? 1 : 0;
      if (who == 1) rem_ls--; else rem_if--;
      last = who;
      exp_own[j] = who;
      exp_cyc[j] = (j == 0) ? 6 : exp_cyc[j-1] + 1 + 6;
    end
    exp_if = {ref_rd(32'h303), ref_rd(32'h302), ref_rd(32'h301), ref_rd(32'h300)};
    exp_ls = {ref_rd(32'h403), ref_rd(32'h402), ref_rd(32'h401), ref_rd(32'h400)};
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'b10; bus.ls_addr = 32'h400;
    nd = 0; n_if = 0; n_ls = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("tie_both", bus.if_done & bus.ls_done, 32'd0);
      who = -1;
      if (bus.ls_done === 1'b1) who = 1;
      else if (bus.if_done === 1'b1) who = 0;
      if (who >= 0) begin
        if (nd < 6) begin
          chk("tie_owner", who, exp_own[nd]);
          chk("tie_cycle", i, exp_cyc[nd]);
          got = (who == 1) ? bus.ls_rdata : bus.if_data;
          chk("tie_data", got, (who == 1) ? exp_ls : exp_if);
        end
        nd++;
        if (who == 1) n_ls++; else n_if++;
      end
      @(posedge clk);
      #1;
      if (n_ls >= 3) bus.ls_req = 1'b0;
      if (n_if >= 3) bus.if_req = 1'b0;
    end
    chk("tie_count", nd, 32'd6);
    clear_inputs();

    // Flush in the second beat kills the fetch; a fresh fetch then returns its own word.
    run_txn(1'b0, 1'b0, 2'b10, 32'h500, 32'h0, 2);
    run_txn(1'b0, 1'b0, 2'b10, 32'h600, 32'h0, -1);
    chk("fetch_fresh", bus.if_data, 32'h63626160);
    // Flush in the request cycle only delays the grant by one cycle.
    run_txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0);
    // Flush never disturbs a store.
    run_txn(1'b1, 1'b1, 2'b10, 32'h700, 32'hDEADBEEF, 2);
    chk("st_word_ram", {ram[13'h703], ram[13'h702], ram[13'h701], ram[13'h700]}, 32'hDEADBEEF);

    // Reset in the middle of a fetch clears every output at the next edge.
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("mrst_if_done", bus.if_done, 32'd0);
    chk("mrst_if_data", bus.if_data, 32'd0);
    chk("mrst_ls_done", bus.ls_done, 32'd0);
    chk("mrst_ls_rdata", bus.ls_rdata, 32'd0);
    chk("mrst_mem_a", bus.mem_a, 32'd0);
    chk("mrst_mem_dout", bus.mem_dout, 32'd0);
    chk("mrst_mem_wr", bus.mem_wr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad_a = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.if_done !== 1'b0 || bus.mem_wr !== 1'b0) bad_a++;
      @(posedge clk);
      #1;
    end
    chk("mrst_quiet", bad_a, 32'd0);

    // Randomized single transactions against the reference memory.
    for (int t = 0; t < 40; t++) begin
      is_ls = 1'($urandom_range(1, 0));
      we    = 1'($urandom_range(1, 0));
      len   = 2'($urandom_range(3, 0));
      if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
      else a = 32'h1000 + 32'($urandom_range(255, 0));
      wd = $urandom;
      fc = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      run_txn(is_ls, we, len, a, wd, fc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
